event_flag_seq: RTL

EVENT_FLAG_SEQ -- requirements
Module: event_flag_seq

---
 rtl/snake_pkg.sv | 20 ++
 rtl/event_flag_seq_edge_det.sv | 22 ++
 rtl/event_flag_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game event/flag sequencing logic.
package snake_pkg;

  localparam int DEF_SCORE_TICKS = 500;
  localparam int DEF_BLINK_TICKS = 250;
  localparam int DEF_CNT_W       = 16;

  // One-hot encoding so at most one animation flag can ever be decoded high.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SCORE = 4'b0010,
    ST_DEAD  = 4'b0100,
    ST_WIN   = 4'b1000
  } state_t;

  function automatic logic is_animating(input state_t s);
    return (s == ST_SCORE) || (s == ST_DEAD) || (s == ST_WIN);
  endfunction

endpackage

// File: rtl/event_flag_seq_edge_det.sv
// Rising-edge detector: registers the input every clk and pulses on a 0->1 change.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_rise
);

  logic r_prev;

  // previous-sample register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_in;
    end
  end

  assign o_rise = i_in & ~r_prev;

endmodule

// File: rtl/event_flag_seq.sv
// Game event sequencer: turns eat/dead/win edges into held animation flags
// (timed score, blinking dead, steady win) with restart and freeze control.
module event_flag_seq
  import snake_pkg::*;
#(
  parameter int SCORE_TICKS = DEF_SCORE_TICKS,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic eat_in,
  input  logic dead_in,
  input  logic win_in,
  input  logic restart,
  output logic score_flag,
  output logic dead_flag,
  output logic win_flag,
  output logic game_freeze
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_TICKS - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

  logic             w_eat_rise;
  logic             w_dead_rise;
  logic             w_win_rise;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dead_nxt;
  logic             r_score_flag;
  logic             r_dead_flag;
  logic             r_win_flag;
  logic             r_game_freeze;

  edge_det u_eat  (.clk(clk), .rst(rst), .i_in(eat_in),  .o_rise(w_eat_rise));
  edge_det u_dead (.clk(clk), .rst(rst), .i_in(dead_in), .o_rise(w_dead_rise));
  edge_det u_win  (.clk(clk), .rst(rst), .i_in(win_in),  .o_rise(w_win_rise));

  // next-state, counter and blink-phase logic; restart overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dead_nxt  = 1'b0;
    if (restart) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = CNT_ZERO;
          if (w_win_rise) begin
            w_state_nxt = ST_WIN;
          end else if (w_dead_rise) begin
            w_state_nxt = ST_DEAD;
            w_dead_nxt  = 1'b1;
          end else if (w_eat_rise) begin
            w_state_nxt = ST_SCORE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SCORE: begin
          if (w_win_rise) begin
            w_state_nxt = ST_WIN;
            w_cnt_nxt   = CNT_ZERO;
          end else if (w_dead_rise) begin
            w_state_nxt = ST_DEAD;
            w_cnt_nxt   = CNT_ZERO;
            w_dead_nxt  = 1'b1;
          end else if (w_eat_rise) begin
            w_cnt_nxt = CNT_ZERO;
          end else if (tick) begin
            if (r_cnt == SCORE_LAST) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = CNT_ZERO;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        // the dead flag register doubles as the blink phase
        ST_DEAD: begin
          w_dead_nxt = r_dead_flag;
          if (w_win_rise) begin
            w_state_nxt = ST_WIN;
            w_cnt_nxt   = CNT_ZERO;
            w_dead_nxt  = 1'b0;
          end else if (tick) begin
            if (r_cnt == BLINK_LAST) begin
              w_cnt_nxt  = CNT_ZERO;
              w_dead_nxt = ~r_dead_flag;
            end else begin
              w_cnt_nxt = r_cnt + CNT_ONE;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        ST_WIN: begin
          w_state_nxt = ST_WIN;
          w_cnt_nxt   = CNT_ZERO;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // state, counter and output registers; flags decode the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= CNT_ZERO;
      r_score_flag  <= 1'b0;
      r_dead_flag   <= 1'b0;
      r_win_flag    <= 1'b0;
      r_game_freeze <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_score_flag  <= (w_state_nxt == ST_SCORE);
      r_dead_flag   <= w_dead_nxt;
      r_win_flag    <= (w_state_nxt == ST_WIN);
      r_game_freeze <= is_animating(w_state_nxt);
    end
  end

  assign score_flag  = r_score_flag;
  assign dead_flag   = r_dead_flag;
  assign win_flag    = r_win_flag;
  assign game_freeze = r_game_freeze;

endmodule
